i2c_master_regif: RTL and testbench
===================================

Name: i2c_master_regif

Overview:
- Byte-oriented I2C bus master with a parallel register-port host interface. There is no Wishbone address/data bus.
- The host presents full register images on dedicated input ports and strobes `cs_i`. All register contents are always visible on output ports.
- Drives the open-drain SCL/SDA pads through pad/output-enable pairs. Sits between a host controller and board-level I2C pull-ups and slaves.

Parameters:
- None. The bus rate is set at run time by the prescale register.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, synchronous, active-high
- prer_i  in  16  prescale register write image
- ctr_i  in  8  control register image; bit7 EN, others reserved
- txr_i  in  8  transmit byte image
- rxr_i  in  8  unused, ignored (rxr is read-only)
- cr_i  in  8  command image: b7 STA, b6 STO, b5 RD, b4 WR, b3 ACK, b0 IACK
- sr_i  in  8  unused, ignored (sr is read-only)
- cs_i  in  1  access strobe, held until ack_o
- prer_o, ctr_o, txr_o, rxr_o, cr_o, sr_o  out  16/8/8/8/8/8  live register contents
- ack_o  out  1  access acknowledge
- scl_pad_i, sda_pad_i  in  1  sensed bus lines
- scl_pad_o, sda_pad_o  out  1  always 0
- scl_padoen_o, sda_padoen_o  out  1  1 = release line, 0 = drive low

Behaviour:
- Reset values: prer=0xFFFF; ctr, txr, rxr, cr, sr = 0; ack_o=0; both padoen=1.
- Access handshake:
  - On an edge with cs_i=1 and ack_o=0: ack_o<=1 and the writes happen.
  - ack_o is 1 for exactly one cycle, then 0, even if cs_i stays high. A held cs_i re-accesses every two cycles.
- Writes per access:
  - prer<=prer_i, ctr<=ctr_i, txr<=txr_i, always.
  - cr_i[7:4] are accepted only if TIP=0 and ctr.EN=1. cr.ACK is loaded together with them.
  - cr_i[0] (IACK) clears IF in any state.
  - A repeated access while TIP=1 is harmless.
- Status register sr: b7 RxACK, b6 BUSY, b1 TIP, b0 IF; others 0.
- TIP:
  - Rises the clock after an accepted command with any of STA/STO/RD/WR set.
  - Falls when the sequence completes. IF=1 at the same edge.
  - cr[7:4] are cleared at completion; cr_o[0] always reads 0.
- Timing: tick every prer+1 clocks. Each bit step has 4 tick phases A–D, so SCL period = 4*(prer+1) clocks.
- Command sequence, in order:
  - START if STA.
  - If WR: 8 bits of txr MSB-first, then a 9th bit read, stored as RxACK.
  - Else if RD: 8 read bits into rxr MSB-first, then drive the ack bit = cr.ACK (0 = ACK).
  - STOP if STO.
  - WR has priority over RD.
- START phases: A SDA rel/SCL keep; B SCL rel; C SDA low; D SCL low. Valid as a repeated start.
- STOP phases: A SDA low/SCL low; B SCL rel; C hold; D SDA rel.
- WRITE bit phases: A set SDA (0 → drive, 1 → release) with SCL low; B–C SCL rel; D SCL low.
- READ bit phases: same as WRITE bit with SDA released; sample sda_pad_i at end of C.
- BUSY: set by START, cleared by STOP completion.
- ctr.EN=0: controller aborts to idle, both lines released; TIP, BUSY cleared; cr[7:4] cleared.
- Reset mid-transfer: everything returns to reset values immediately.
- Bus arbitration is not supported; sr bit5 reads 0.

Optional Feature:
- I2C_CLK_STRETCH_EN
- Defined: after releasing SCL in phase B, the phase counter halts until scl_pad_i reads 1. A slave holding SCL low stretches the bit.
- Undefined: scl_pad_i is ignored and timing is purely prescale-driven.

Test Plan:
- Handshake and write-through: wb_rst_i then cs_i with prer_i=0x00C8 → ack_o one cycle later for one cycle; prer_o=0x00C8; sr_o=0.
- Write transfer: ctr_i=0x80; txr=0x20 with cr=0x90 → TIP=1 the next cycle; START and 9 SCL pulses; slave model at address 0x10 ACKs; TIP→0, RxACK=0, BUSY=1. Then txr=0x01 with cr=0x10, txr=0xA5 with cr=0x10, txr=0x5A with cr=0x50 → STOP, BUSY=0.
- Read transfer: addr 0x20 with cr=0x90, then 0x01 with cr=0x10, then 0x21 with cr=0x90 (repeated start). cr=0x20 → rxr_o=0xA5; cr=0x20 again → rxr_o=0x5A.
- Re-access while TIP=1 with cr_i unchanged → no second transfer; SCL pulse count stays 9.
- Absent slave: txr=0x7E with cr=0x90 → RxACK=1 after TIP falls. ctr.EN=0 with cr=0x90 → no bus activity, TIP stays 0.
- I2C_CLK_STRETCH_EN: hold scl low for 10000 clocks mid-byte → transfer completes correctly, delayed by the hold. Without the macro, the bit timing is unchanged.

Source files
------------

// File: rtl/i2c_master_regif.sv
// rtl/i2c_master_regif.sv - byte-oriented I2C master with a parallel register-image host port
// Optional: define I2C_CLK_STRETCH_EN to let a slave stretch SCL during the high phase.
`timescale 1ns/1ps

module i2c_master_regif (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] prer_i,
  input  logic [7:0]  ctr_i,
  input  logic [7:0]  txr_i,
  input  logic [7:0]  rxr_i,
  input  logic [7:0]  cr_i,
  input  logic [7:0]  sr_i,
  input  logic        cs_i,
  output logic [15:0] prer_o,
  output logic [7:0]  ctr_o,
  output logic [7:0]  txr_o,
  output logic [7:0]  rxr_o,
  output logic [7:0]  cr_o,
  output logic [7:0]  sr_o,
  output logic        ack_o,
  input  logic        scl_pad_i,
  input  logic        sda_pad_i,
  output logic        scl_pad_o,
  output logic        sda_pad_o,
  output logic        scl_padoen_o,
  output logic        sda_padoen_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;
  localparam logic [1:0] PH_D = 2'd3;

  logic [15:0] r_prer;
  logic [7:0]  r_ctr;
  logic [7:0]  r_txr;
  logic [7:0]  r_rxr;
  logic [3:0]  r_cmd;
  logic        r_ack_bit;
  logic        r_rxack;
  logic        r_busy;
  logic        r_tip;
  logic        r_if;
  logic        r_ack;
  logic [2:0]  r_state;
  logic [1:0]  r_phase;
  logic [3:0]  r_bit;
  logic [7:0]  r_shift;
  logic [15:0] r_cnt;
  logic        r_scl_oen;
  logic        r_sda_oen;

  logic        w_access;
  logic        w_accept;
  logic        w_stall;
  logic        w_sta;
  logic        w_sto;
  logic        w_rd;
  logic        w_wr;
  logic [2:0]  w_after_start;
  logic [2:0]  w_after_data;
  logic [2:0]  w_entry;
  logic [2:0]  w_step_next;
  logic        w_bit_out;
  logic        w_scl_oen_d;
  logic        w_sda_oen_d;
  logic        w_unused;

  assign w_access = cs_i & ~r_ack;
  assign w_accept = w_access & ~r_tip & ctr_i[7];
  assign {w_sta, w_sto, w_rd, w_wr} = r_cmd;
  assign w_unused = ^{rxr_i, sr_i, cr_i[2:1], scl_pad_i};

`ifdef I2C_CLK_STRETCH_EN
  // Only stall once our own release has reached the pad; a low line then means a slave holds it.
  assign w_stall = (r_state != ST_IDLE) && (r_phase == PH_B) && r_scl_oen && !scl_pad_i;
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_after_start = ST_IDLE;
    if (w_wr)
      w_after_start = ST_WRITE;
    else if (w_rd)
      w_after_start = ST_READ;
    else if (w_sto)
      w_after_start = ST_STOP;
    w_after_data = w_sto ? ST_STOP : ST_IDLE;
    w_entry      = w_sta ? ST_START : w_after_start;
    case (r_state)
      ST_START:          w_step_next = w_after_start;
      ST_WRITE, ST_READ: w_step_next = w_after_data;
      default:           w_step_next = ST_IDLE;
    endcase
  end

  // Ninth bit: WRITE releases SDA for the slave ACK, READ drives our ACK/NACK.
  always_comb begin
    w_bit_out = 1'b1;
    if (r_state == ST_WRITE)
      w_bit_out = (r_bit == 4'd8) ? 1'b1 : r_shift[7];
    else if (r_state == ST_READ)
      w_bit_out = (r_bit == 4'd8) ? r_ack_bit : 1'b1;
  end

  always_comb begin
    w_scl_oen_d = r_scl_oen;
    w_sda_oen_d = r_sda_oen;
    case (r_state)
      ST_START: begin
        case (r_phase)
          PH_A:    w_sda_oen_d = 1'b1;
          PH_B:    w_scl_oen_d = 1'b1;
          PH_C:    w_sda_oen_d = 1'b0;
          default: w_scl_oen_d = 1'b0;
        endcase
      end
      ST_WRITE, ST_READ: begin
        w_scl_oen_d = (r_phase == PH_B) || (r_phase == PH_C);
        if (r_phase == PH_A)
          w_sda_oen_d = w_bit_out;
      end
      ST_STOP: begin
        case (r_phase)
          PH_A: begin
            w_sda_oen_d = 1'b0;
            w_scl_oen_d = 1'b0;
          end
          PH_B:    w_scl_oen_d = 1'b1;
          PH_C:    w_scl_oen_d = 1'b1;
          default: w_sda_oen_d = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_prer    <= 16'hFFFF;
      r_ctr     <= 8'h00;
      r_txr     <= 8'h00;
      r_rxr     <= 8'h00;
      r_cmd     <= 4'h0;
      r_ack_bit <= 1'b0;
      r_rxack   <= 1'b0;
      r_busy    <= 1'b0;
      r_tip     <= 1'b0;
      r_if      <= 1'b0;
      r_ack     <= 1'b0;
      r_state   <= ST_IDLE;
      r_phase   <= PH_A;
      r_bit     <= 4'd0;
      r_shift   <= 8'h00;
      r_cnt     <= 16'h0000;
      r_scl_oen <= 1'b1;
      r_sda_oen <= 1'b1;
    end else begin
      r_ack     <= w_access;
      r_scl_oen <= w_scl_oen_d;
      r_sda_oen <= w_sda_oen_d;

      if (!r_ctr[7]) begin
        r_state   <= ST_IDLE;
        r_phase   <= PH_A;
        r_bit     <= 4'd0;
        r_tip     <= 1'b0;
        r_busy    <= 1'b0;
        r_cmd     <= 4'h0;
        r_scl_oen <= 1'b1;
        r_sda_oen <= 1'b1;
      end else if (r_state == ST_IDLE) begin
        if (r_cmd != 4'h0) begin
          r_tip   <= 1'b1;
          r_state <= w_entry;
          r_phase <= PH_A;
          r_bit   <= 4'd0;
          r_cnt   <= r_prer;
          r_shift <= r_txr;
        end
      end else if (!w_stall) begin
        if (r_cnt != 16'h0000) begin
          r_cnt <= r_cnt - 16'd1;
        end else begin
          r_cnt <= r_prer;
          if (r_phase != PH_D) begin
            r_phase <= r_phase + 2'd1;
            if (r_phase == PH_C) begin
              if (r_state == ST_START)
                r_busy <= 1'b1;
              if (r_state == ST_WRITE && r_bit == 4'd8)
                r_rxack <= sda_pad_i;
              if (r_state == ST_READ && r_bit < 4'd8) begin
                r_shift <= {r_shift[6:0], sda_pad_i};
                if (r_bit == 4'd7)
                  r_rxr <= {r_shift[6:0], sda_pad_i};
              end
            end
          end else begin
            r_phase <= PH_A;
            if ((r_state == ST_WRITE || r_state == ST_READ) && r_bit != 4'd8) begin
              r_bit <= r_bit + 4'd1;
              if (r_state == ST_WRITE)
                r_shift <= {r_shift[6:0], 1'b0};
            end else begin
              r_state <= w_step_next;
              r_bit   <= 4'd0;
              if (r_state == ST_STOP)
                r_busy <= 1'b0;
              if (w_step_next == ST_IDLE) begin
                r_tip <= 1'b0;
                r_if  <= 1'b1;
                r_cmd <= 4'h0;
              end
            end
          end
        end
      end

      // Host writes come last so an accepted command wins over an abort clear in the same cycle.
      if (w_access) begin
        r_prer <= prer_i;
        r_ctr  <= ctr_i;
        r_txr  <= txr_i;
        if (w_accept) begin
          r_cmd     <= cr_i[7:4];
          r_ack_bit <= cr_i[3];
        end
        if (cr_i[0])
          r_if <= 1'b0;
      end
    end
  end

  assign prer_o       = r_prer;
  assign ctr_o        = r_ctr;
  assign txr_o        = r_txr;
  assign rxr_o        = r_rxr;
  assign cr_o         = {r_cmd, r_ack_bit, 3'b000};
  assign sr_o         = {r_rxack, r_busy, 4'b0000, r_tip, r_if};
  assign ack_o        = r_ack;
  assign scl_pad_o    = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign scl_padoen_o = r_scl_oen;
  assign sda_padoen_o = r_sda_oen;

endmodule

// File: tb/tb_i2c_master_regif.sv
// tb/tb_i2c_master_regif.sv - directed bench for i2c_master_regif with an I2C slave model at 0x10
`timescale 1ns/1ps

module tb_i2c_master_regif;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] prer_i;
  logic [7:0]  ctr_i, txr_i, rxr_i, cr_i, sr_i;
  logic        cs_i;
  logic [15:0] prer_o;
  logic [7:0]  ctr_o, txr_o, rxr_o, cr_o, sr_o;
  logic        ack_o;
  logic        scl_line, sda_line;
  logic        scl_pad_o, sda_pad_o, scl_padoen_o, sda_padoen_o;
  logic        scl_hold = 1'b0;

  localparam int SS_IDLE  = 0;
  localparam int SS_ADDR  = 1;
  localparam int SS_WDATA = 2;
  localparam int SS_READ  = 3;

  logic       s_scl_d, s_sda_d, s_sda_oen, s_rw, s_first, s_mack;
  logic [7:0] s_shift, s_ptr;
  logic [7:0] s_mem [0:255];
  int         s_state, s_bitcnt;
  int         scl_rises = 0;
  int         tip_cnt = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         base_rises, base_tip, wait_n;

  always #5 clk = ~clk;

  assign scl_line = scl_padoen_o & ~scl_hold;
  assign sda_line = sda_padoen_o & s_sda_oen;

  i2c_master_regif dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .prer_i(prer_i), .ctr_i(ctr_i), .txr_i(txr_i), .rxr_i(rxr_i), .cr_i(cr_i), .sr_i(sr_i),
    .cs_i(cs_i),
    .prer_o(prer_o), .ctr_o(ctr_o), .txr_o(txr_o), .rxr_o(rxr_o), .cr_o(cr_o), .sr_o(sr_o),
    .ack_o(ack_o),
    .scl_pad_i(scl_line), .sda_pad_i(sda_line),
    .scl_pad_o(scl_pad_o), .sda_pad_o(sda_pad_o),
    .scl_padoen_o(scl_padoen_o), .sda_padoen_o(sda_padoen_o)
  );

  always @(posedge clk) begin
    if (sr_o[1])
      tip_cnt <= tip_cnt + 1;
  end

  // Slave: address 0x10, first written byte sets the pointer, pointer auto-increments.
  always @(negedge clk) begin
    s_scl_d <= scl_line;
    s_sda_d <= sda_line;
    if (!rst && !s_scl_d && scl_line)
      scl_rises <= scl_rises + 1;
    if (rst) begin
      s_state   <= SS_IDLE;
      s_sda_oen <= 1'b1;
      s_bitcnt  <= 0;
      s_ptr     <= 8'h00;
      s_first   <= 1'b0;
      s_rw      <= 1'b0;
      s_mack    <= 1'b0;
      s_shift   <= 8'h00;
      for (int i = 0; i < 256; i++)
        s_mem[i] <= 8'h00;
      s_mem[3] <= 8'h3C;
    end else if (s_scl_d && scl_line && s_sda_d && !sda_line) begin
      s_state   <= SS_ADDR;
      s_bitcnt  <= 0;
      s_sda_oen <= 1'b1;
    end else if (s_scl_d && scl_line && !s_sda_d && sda_line) begin
      s_state   <= SS_IDLE;
      s_sda_oen <= 1'b1;
    end else if (!s_scl_d && scl_line) begin
      s_bitcnt <= s_bitcnt + 1;
      if (s_bitcnt < 8 && s_state != SS_READ)
        s_shift <= {s_shift[6:0], sda_line};
      if (s_bitcnt == 8 && s_state == SS_READ)
        s_mack <= !sda_line;
    end else if (s_scl_d && !scl_line) begin
      if (s_bitcnt == 8) begin
        case (s_state)
          SS_ADDR: begin
            if (s_shift[7:1] == 7'h10) begin
              s_sda_oen <= 1'b0;
              s_rw      <= s_shift[0];
            end else begin
              s_state <= SS_IDLE;
            end
          end
          SS_WDATA: begin
            s_sda_oen <= 1'b0;
            s_first   <= 1'b0;
            if (s_first) begin
              s_ptr <= s_shift;
            end else begin
              s_mem[s_ptr] <= s_shift;
              s_ptr        <= s_ptr + 8'd1;
            end
          end
          default: s_sda_oen <= 1'b1;
        endcase
      end else if (s_bitcnt == 9) begin
        s_bitcnt  <= 0;
        s_sda_oen <= 1'b1;
        if ((s_state == SS_ADDR && s_rw) || (s_state == SS_READ && s_mack)) begin
          s_state   <= SS_READ;
          s_shift   <= s_mem[s_ptr];
          s_sda_oen <= s_mem[s_ptr][7];
          s_ptr     <= s_ptr + 8'd1;
        end else if (s_state == SS_ADDR) begin
          s_state <= SS_WDATA;
          s_first <= 1'b1;
        end else if (s_state == SS_READ) begin
          s_state <= SS_IDLE;
        end
      end else if (s_state == SS_READ && s_bitcnt >= 1 && s_bitcnt <= 7) begin
        s_sda_oen <= s_shift[7 - s_bitcnt];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic host_access(input logic [7:0] ctr, input logic [7:0] txr, input logic [7:0] cr);
    int n;
    @(negedge clk);
    ctr_i = ctr;
    txr_i = txr;
    cr_i  = cr;
    cs_i  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ack_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ack_o)
      check("ack_timeout", 32'(ack_o), 32'd1);
    cs_i = 1'b0;
  endtask

  task automatic wait_tip_low(input string tag);
    int n;
    n = 0;
    while (sr_o[1] && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(sr_o[1]), 32'd0);
  endtask

  task automatic run_cmd(input logic [7:0] txr, input logic [7:0] cr);
    host_access(8'h80, txr, cr);
    @(negedge clk);
    wait_tip_low("cmd_done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cs_i = 1'b0;
    prer_i = 16'h0000;
    ctr_i = 8'h00; txr_i = 8'h00; rxr_i = 8'h00; cr_i = 8'h00; sr_i = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_prer", 32'(prer_o), 32'hFFFF);
    check("rst_ctr", 32'(ctr_o), 32'h0);
    check("rst_txr_rxr", 32'({txr_o, rxr_o}), 32'h0);
    check("rst_cr_sr", 32'({cr_o, sr_o}), 32'h0);
    check("rst_ack", 32'(ack_o), 32'h0);
    check("rst_padoen", 32'({scl_padoen_o, sda_padoen_o}), 32'h3);
    check("rst_pad_o", 32'({scl_pad_o, sda_pad_o}), 32'h0);

    // Handshake with cs_i held: ack pulses every other cycle.
    prer_i = 16'h00C8;
    cs_i = 1'b1;
    check("hs_ack_before", 32'(ack_o), 32'd0);
    @(negedge clk);
    check("hs_ack_first", 32'(ack_o), 32'd1);
    check("hs_prer", 32'(prer_o), 32'h00C8);
    check("hs_sr", 32'(sr_o), 32'h00);
    @(negedge clk);
    check("hs_ack_drop", 32'(ack_o), 32'd0);
    @(negedge clk);
    check("hs_ack_again", 32'(ack_o), 32'd1);
    cs_i = 1'b0;
    @(negedge clk);
    check("hs_ack_idle", 32'(ack_o), 32'd0);

    // Address write with cs_i held for 40 cycles: re-accesses must not restart the transfer.
    prer_i = 16'd4;
    base_rises = scl_rises;
    base_tip = tip_cnt;
    ctr_i = 8'h80; txr_i = 8'h20; cr_i = 8'h90; cs_i = 1'b1;
    @(negedge clk);
    check("wr_ack", 32'(ack_o), 32'd1);
    @(negedge clk);
    check("wr_tip_rise", 32'(sr_o[1]), 32'd1);
    check("wr_cr_live", 32'(cr_o), 32'h90);
    repeat (40) @(negedge clk);
    cs_i = 1'b0;
    wait_tip_low("wr_addr_done");
    check("wr_scl_pulses", 32'(scl_rises - base_rises), 32'd9);
    check("wr_tip_cycles", 32'(tip_cnt - base_tip), 32'd200);
    check("wr_sr", 32'(sr_o), 32'h41);
    check("wr_cr_cleared", 32'(cr_o), 32'h00);
    repeat (50) @(negedge clk);
    check("wr_no_retrigger", 32'(scl_rises - base_rises), 32'd9);

    host_access(8'h80, 8'h20, 8'h01);
    @(negedge clk);
    check("iack_clears_if", 32'(sr_o), 32'h40);

    run_cmd(8'h01, 8'h10);
    check("wr_ptr_sr", 32'(sr_o), 32'h41);
    run_cmd(8'hA5, 8'h10);
    base_tip = tip_cnt;
    run_cmd(8'h5A, 8'h50);
    check("wr_stop_sr", 32'(sr_o), 32'h01);
    check("wr_stop_tip_cycles", 32'(tip_cnt - base_tip), 32'd200);
    check("wr_stop_lines", 32'({scl_padoen_o, sda_padoen_o}), 32'h3);
    check("slave_mem1", 32'(s_mem[1]), 32'hA5);
    check("slave_mem2", 32'(s_mem[2]), 32'h5A);

    // Read back through a repeated start.
    run_cmd(8'h20, 8'h90);
    run_cmd(8'h01, 8'h10);
    run_cmd(8'h21, 8'h90);
    check("rd_addr_sr", 32'(sr_o), 32'h41);
    run_cmd(8'h00, 8'h20);
    check("rd_byte1", 32'(rxr_o), 32'hA5);
    run_cmd(8'h00, 8'h20);
    check("rd_byte2", 32'(rxr_o), 32'h5A);
    run_cmd(8'h00, 8'h68);
    check("rd_byte3_nack", 32'(rxr_o), 32'h3C);
    check("rd_stop_sr", 32'(sr_o), 32'h01);

`ifdef I2C_CLK_STRETCH_EN
    base_tip = tip_cnt;
    host_access(8'h80, 8'h20, 8'h90);
    @(negedge clk);
    wait_n = 0;
    while (((tip_cnt - base_tip) < 60 || scl_padoen_o) && wait_n < 500) begin
      @(negedge clk);
      wait_n++;
    end
    scl_hold = 1'b1;
    repeat (10000) @(negedge clk);
    scl_hold = 1'b0;
    wait_tip_low("stretch_done");
    check("stretch_delayed", 32'((tip_cnt - base_tip) > 10100 && (tip_cnt - base_tip) < 10300), 32'd1);
    check("stretch_sr", 32'(sr_o), 32'h41);
    run_cmd(8'h00, 8'h40);
    check("stretch_stop_sr", 32'(sr_o), 32'h01);
`endif

    // Absent slave: nobody pulls the ninth bit low.
    run_cmd(8'h7E, 8'h90);
    check("absent_rxack", 32'(sr_o), 32'hC1);

    host_access(8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("abort_sr", 32'(sr_o), 32'h81);
    check("abort_lines", 32'({scl_padoen_o, sda_padoen_o}), 32'h3);
    base_rises = scl_rises;
    host_access(8'h00, 8'h00, 8'h90);
    repeat (60) @(negedge clk);
    check("dis_tip", 32'(sr_o[1]), 32'd0);
    check("dis_no_scl", 32'(scl_rises - base_rises), 32'd0);
    check("dis_cr", 32'(cr_o), 32'h00);

    // Reset in the middle of a transfer.
    host_access(8'h80, 8'h20, 8'h90);
    repeat (30) @(negedge clk);
    check("mid_tip", 32'(sr_o[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_prer", 32'(prer_o), 32'hFFFF);
    check("mid_rst_regs", 32'({ctr_o, txr_o, cr_o, sr_o}), 32'h0);
    check("mid_rst_lines", 32'({scl_padoen_o, sda_padoen_o}), 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
